// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// standard or first-word-fall-through read, synchronous flush and occupancy output.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               wr_en,
    input  logic [FIFO_WIDTH-1:0]              data_in,
    input  logic                               rd_en,
    output logic [FIFO_WIDTH-1:0]              data_out,
    output logic                               rd_valid,
    output logic                               wr_ack,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               full,
    output logic                               empty,
    output logic                               almostfull,
    output logic                               almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          wr_ack_reg, overflow_reg, underflow_reg;
    logic          wr_ok, rd_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full        = (count_reg == DEPTH_C);
        empty       = (count_reg == '0);
        almostfull  = (count_reg >= AF_C);
        almostempty = (count_reg != '0) && (count_reg <= AE_C);
        rd_ok       = rd_en && !empty;
        wr_ok       = wr_en && (!full || rd_ok);
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (rd_ok) rd_ptr_next = ptr_inc(rd_ptr_reg);
            if (wr_ok && !rd_ok)      count_next = count_reg + CW'(1);
            else if (rd_ok && !wr_ok) count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ack_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ack_reg    <= wr_ok;
            overflow_reg  <= wr_en && !wr_ok;
            underflow_reg <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is never cleared; only the pointers are.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_ok) mem[wr_ptr_reg] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr_reg];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] data_out_reg;
            logic                  rd_valid_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_out_reg <= '0;
                    rd_valid_reg <= 1'b0;
                end else if (flush) begin
                    rd_valid_reg <= 1'b0;
                end else if (rd_ok) begin
                    data_out_reg <= mem[rd_ptr_reg];
                    rd_valid_reg <= 1'b1;
                end else begin
                    rd_valid_reg <= 1'b0;
                end
            end

            assign data_out = data_out_reg;
            assign rd_valid = rd_valid_reg;
        end
    endgenerate

    assign wr_ack    = wr_ack_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
    assign count     = count_reg;
endmodule
